// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH independent JK flip-flops sharing one clock, with enable,
// parallel load, synchronous up/down count modes, a saturating change-event
// counter and registered change/wrap pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en         advance enable (load is honoured even when low)
//   mode       00 per-bit JK, 01 count up, 10 count down, 11 hold
//   load       synchronous parallel load of d (beats en and mode)
//   d          parallel load data
//   j, k       per-bit JK inputs, used in mode 00 only
//   clr_cnt    synchronous clear of toggle_cnt (beats an increment)
//   q          register state
//   q_bar      combinational ~q
//   changed    one-cycle pulse, aligned with the q value that differs
//   wrap       one-cycle pulse, aligned with the q value after a wrap
//   toggle_cnt saturating count of cycles in which q changed
module jk_ff_bank #(
    parameter int unsigned     WIDTH     = 4,
    parameter int unsigned     CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             changed,
    output logic             wrap,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [1:0] ModeJk   = 2'b00;
    localparam logic [1:0] ModeUp   = 2'b01;
    localparam logic [1:0] ModeDown = 2'b10;
    localparam logic [1:0] ModeHold = 2'b11;

    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             change_next;

    assign q_bar = ~q;

    // Synchronous-counter toggle enables: a cell toggles (J=K=1) when all
    // lower cells are 1 (up) or all lower cells are 0 (down).
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = d;
        end else if (en) begin
            unique case (mode)
                ModeJk: begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        unique case ({j[i], k[i]})
                            2'b00:   q_next[i] = q[i];
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            default: q_next[i] = ~q[i];
                        endcase
                    end
                end
                ModeUp: begin
                    q_next    = q ^ t_up;
                    wrap_next = &q;
                end
                ModeDown: begin
                    q_next    = q ^ t_dn;
                    wrap_next = ~|q;
                end
                ModeHold: q_next = q;
                default:  q_next = q;
            endcase
        end
    end

    assign change_next = (q_next != q);

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= RESET_VAL;
            changed    <= 1'b0;
            wrap       <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            q       <= q_next;
            changed <= change_next;
            wrap    <= wrap_next;
            if (clr_cnt) begin
                toggle_cnt <= '0;
            end else if (change_next && (toggle_cnt != {CNT_W{1'b1}})) begin
                toggle_cnt <= toggle_cnt + CNT_W'(1);
            end
        end
    end

endmodule
